// File: rtl/icache_fetch.sv
// Direct-mapped, one-word-per-line instruction cache with a byte-serial miss
// fill engine on an arbitrated byte-wide memory bus.
module icache_fetch #(
  parameter int unsigned INDEX_BITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] req_pc,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_inst,
  output logic        resp_hit,
  output logic        busy,
  output logic        mem_req,
  input  logic        mem_grant,
  output logic [31:0] mem_a,
  input  logic [7:0]  mem_din
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 30 - INDEX_BITS;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              ic_q, rc_q;
  logic                    pend_q;
  logic [29:0]             base_q;
  logic [23:0]             buf_q;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];

  logic [INDEX_BITS-1:0]   req_idx, base_idx;
  logic [TAG_W-1:0]        req_tag, base_tag;
  logic                    hit_c, hit_rsp, start, issue, fill;
  logic                    pc_unused;

  assign req_idx   = req_pc[INDEX_BITS+1:2];
  assign req_tag   = req_pc[31:INDEX_BITS+2];
  assign base_idx  = base_q[INDEX_BITS-1:0];
  assign base_tag  = base_q[29:INDEX_BITS];
  assign hit_c     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign busy      = (state_q != IDLE);
  assign pc_unused = ^req_pc[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and bus issue; flush overrides everything in flight
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_a   = 32'd0;
    hit_rsp = 1'b0;
    start   = 1'b0;
    issue   = 1'b0;
    fill    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit_c) hit_rsp = 1'b1;
          else begin
            start   = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        mem_req = (ic_q < 3'd4);
        if (mem_req && mem_grant) begin
          issue = 1'b1;
          mem_a = {base_q, ic_q[1:0]};
        end
        if (pend_q && rc_q == 3'd3) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      hit_rsp = 1'b0;
      start   = 1'b0;
      fill    = 1'b0;
    end
  end

  // Fill counters, byte assembly, valid bits and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_q       <= 3'd0;
      rc_q       <= 3'd0;
      pend_q     <= 1'b0;
      base_q     <= 30'd0;
      buf_q      <= 24'd0;
      valid_q    <= '0;
      resp_valid <= 1'b0;
      resp_inst  <= 32'd0;
      resp_hit   <= 1'b0;
    end else begin
      resp_valid <= hit_rsp | fill;
      if (flush || start) begin
        ic_q   <= 3'd0;
        rc_q   <= 3'd0;
        pend_q <= 1'b0;
        if (start) base_q <= req_pc[31:2];
      end else begin
        pend_q <= issue;
        if (issue) ic_q <= ic_q + 3'd1;
        if (pend_q && state_q == FETCH) begin
          rc_q <= rc_q + 3'd1;
          case (rc_q)
            3'd0:    buf_q[7:0]   <= mem_din;
            3'd1:    buf_q[15:8]  <= mem_din;
            3'd2:    buf_q[23:16] <= mem_din;
            default: ;
          endcase
        end
      end
      if (hit_rsp) begin
        resp_inst <= data_mem[req_idx];
        resp_hit  <= 1'b1;
      end
      if (fill) begin
        resp_inst         <= {mem_din, buf_q};
        resp_hit          <= 1'b0;
        valid_q[base_idx] <= 1'b1;
      end
    end
  end

  // Tag/data storage needs no reset; valid bits gate every read
  always_ff @(posedge clk) begin
    if (fill && !rst) begin
      tag_mem[base_idx]  <= base_tag;
      data_mem[base_idx] <= {mem_din, buf_q};
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: byte RAM model with one-cycle read latency
// and hand-computed expected words, latencies and bus addresses.
module tb_icache_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] req_pc;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        resp_hit;
  logic        busy;
  logic        mem_req;
  logic        mem_grant;
  logic [31:0] mem_a;
  logic [7:0]  mem_din;

  logic [7:0]  ram [1024];
  logic [31:0] alog [0:20];
  int          n_assert = 0;
  int          n_fail = 0;
  int          rv_seen;

  icache_fetch #(.INDEX_BITS(7)) dut (
    .clk(clk), .rst(rst), .req(req), .req_pc(req_pc), .flush(flush),
    .resp_valid(resp_valid), .resp_inst(resp_inst), .resp_hit(resp_hit),
    .busy(busy), .mem_req(mem_req), .mem_grant(mem_grant), .mem_a(mem_a),
    .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_din <= ram[mem_a[9:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request, run until resp_valid (bounded), check latency and result
  task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] exp_inst,
                       input logic exp_hit, input int exp_lat, input logic [31:0] gnt_low);
    int lat;
    lat = 0;
    for (int i = 0; i <= 20; i++) alog[i] = 32'hdead_beef;
    req = 1'b1;
    req_pc = pc;
    next_cycle();
    req = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      mem_grant = !gnt_low[c];
      #1;
      alog[c] = mem_a;
      if (c == 1) chk({tag, "_busy_c1"}, 32'(busy), 32'(!exp_hit));
      if (c == 1 && exp_hit) chk({tag, "_hit_mem_req"}, 32'(mem_req), 32'd0);
      if (resp_valid) lat = c;
      else next_cycle();
    end
    mem_grant = 1'b1;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_inst"}, resp_inst, exp_inst);
    chk({tag, "_hit"}, 32'(resp_hit), 32'(exp_hit));
    chk({tag, "_busy_resp"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h000] = 8'h13; ram[10'h001] = 8'h05;
    ram[10'h010] = 8'h93; ram[10'h011] = 8'h00; ram[10'h012] = 8'h10; ram[10'h013] = 8'h00;
    ram[10'h020] = 8'h13; ram[10'h021] = 8'h01; ram[10'h022] = 8'h20; ram[10'h023] = 8'h00;
    ram[10'h040] = 8'hb7; ram[10'h041] = 8'h00; ram[10'h042] = 8'h01; ram[10'h043] = 8'h00;
    ram[10'h200] = 8'h37; ram[10'h201] = 8'h12;

    rst = 1'b1; req = 1'b0; req_pc = 32'd0; flush = 1'b0; mem_grant = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_inst", resp_inst, 32'd0);
    chk("rst_resp_hit", 32'(resp_hit), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    @(negedge clk);

    // Cold miss
    fetch("cold", 32'h0000_0000, 32'h0000_0513, 1'b0, 6, 32'd0);
    for (int c = 1; c <= 4; c++) chk($sformatf("cold_mem_a_c%0d", c), alog[c], 32'(c - 1));
    next_cycle();
    #1;
    chk("hold_valid", 32'(resp_valid), 32'd0);
    chk("hold_inst", resp_inst, 32'h0000_0513);
    @(negedge clk);

    // Hits, including an unaligned PC in the same word
    fetch("hit0", 32'h0000_0000, 32'h0000_0513, 1'b1, 1, 32'd0);
    fetch("hit2", 32'h0000_0002, 32'h0000_0513, 1'b1, 1, 32'd0);

    // Conflict eviction on index 0
    fetch("conf200", 32'h0000_0200, 32'h0000_1237, 1'b0, 6, 32'd0);
    fetch("conf000", 32'h0000_0000, 32'h0000_0513, 1'b0, 6, 32'd0);

    // Grant withheld in cycles 2-3
    fetch("stall", 32'h0000_0010, 32'h0010_0093, 1'b0, 8, 32'h0000_000c);
    chk("stall_a1", alog[1], 32'h10);
    chk("stall_a2", alog[2], 32'h00);
    chk("stall_a3", alog[3], 32'h00);
    chk("stall_a4", alog[4], 32'h11);
    chk("stall_a5", alog[5], 32'h12);
    chk("stall_a6", alog[6], 32'h13);

    // Flush in cycle 3 with a same-cycle request
    rv_seen = 0;
    req = 1'b1; req_pc = 32'h0000_0020;
    next_cycle();
    req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) begin flush = 1'b1; req = 1'b1; req_pc = 32'h0000_0020; end
      #1;
      if (resp_valid) rv_seen++;
      if (c == 4) chk("flush_busy_c4", 32'(busy), 32'd0);
      if (c == 4) chk("flush_mem_req_c4", 32'(mem_req), 32'd0);
      next_cycle();
      flush = 1'b0; req = 1'b0;
    end
    chk("flush_no_resp", 32'(rv_seen), 32'd0);
    fetch("flush_refetch", 32'h0000_0020, 32'h0020_0113, 1'b0, 6, 32'd0);

    // Reset in cycle 2 of a miss invalidates everything
    fetch("pre_rst_hit", 32'h0000_0000, 32'h0000_0513, 1'b1, 1, 32'd0);
    req = 1'b1; req_pc = 32'h0000_0040;
    next_cycle();
    req = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    chk("mrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mrst_resp_inst", resp_inst, 32'd0);
    chk("mrst_resp_hit", 32'(resp_hit), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_mem_req", 32'(mem_req), 32'd0);
    chk("mrst_mem_a", mem_a, 32'd0);
    @(negedge clk);
    fetch("post_rst", 32'h0000_0000, 32'h0000_0513, 1'b0, 6, 32'd0);
    fetch("post_rst_40", 32'h0000_0040, 32'h0001_00b7, 1'b0, 6, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
